// File: rtl/r5p_bus_pkg.sv
// Shared types for the r5p two-to-one memory bus arbiter.
package r5p_bus_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HOLD_IF = 2'd1,
      HOLD_LS = 2'd2
   } arb_state_t;

   typedef enum logic {
      SRC_IF = 1'b0,
      SRC_LS = 1'b1
   } arb_src_t;

endpackage

// File: rtl/r5p_bus_arb_pri.sv
// Combinational grant selection: hold priority, then fairness override, then RR or fixed LS priority.
module r5p_bus_arb_pri
   import r5p_bus_pkg::*;
#(
   parameter bit RR = 1'b0
) (
   input  arb_state_t state,
   input  logic       if_req,
   input  logic       ls_req,
   input  arb_src_t   rr_last,
   input  logic       fair,
   output arb_src_t   gnt_c
);

   always_comb begin
      gnt_c = SRC_IF;
      case (state)
         HOLD_IF: gnt_c = SRC_IF;
         HOLD_LS: gnt_c = SRC_LS;
         default: begin
            if (if_req && ls_req) begin
               if (fair)
                  gnt_c = SRC_IF;
               else if (RR)
                  gnt_c = (rr_last == SRC_IF) ? SRC_LS : SRC_IF;
               else
                  gnt_c = SRC_LS;
            end else if (ls_req) begin
               gnt_c = SRC_LS;
            end
         end
      endcase
   end

endmodule

// File: rtl/r5p_bus_arb.sv
// Shares one memory bus between the fetch (if_*) and load/store (ls_*) ports with zero added latency.
// Optional fairness limit and read-data masking enabled by defining R5P_BUS_ARB_FAIR_EN.
module r5p_bus_arb
   import r5p_bus_pkg::*;
#(
   parameter int unsigned AW   = 32,
   parameter int unsigned DW   = 32,
   parameter int unsigned SW   = DW/8,
   parameter bit          RR   = 1'b0,
   parameter int unsigned MAXC = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_adr,
   output logic [DW-1:0] if_rdt,
   output logic          if_ack,
   input  logic          ls_req,
   input  logic          ls_wen,
   input  logic [AW-1:0] ls_adr,
   input  logic [SW-1:0] ls_sel,
   input  logic [DW-1:0] ls_wdt,
   output logic [DW-1:0] ls_rdt,
   output logic          ls_ack,
   output logic          mem_req,
   output logic          mem_wen,
   output logic [AW-1:0] mem_adr,
   output logic [SW-1:0] mem_sel,
   output logic [DW-1:0] mem_wdt,
   input  logic [DW-1:0] mem_rdt,
   input  logic          mem_ack
);

   if (MAXC == 0) begin : g_maxc_chk
      $error("r5p_bus_arb: MAXC must be at least 1");
   end

   arb_state_t state, state_nxt;
   arb_src_t   rr_last;
   arb_src_t   gnt_c;
   logic       fair_c;
   logic       gnt_req_c;
   logic       xfer_c;

`ifdef R5P_BUS_ARB_FAIR_EN
   localparam int unsigned CW = $clog2(MAXC + 1);

   logic [CW-1:0] cnt;
   arb_src_t      own;
   logic          rd_pend;

   assign fair_c = (cnt == CW'(MAXC));
`else
   assign fair_c = 1'b0;
`endif

   r5p_bus_arb_pri #(
      .RR (RR)
   ) u_pri (
      .state   (state),
      .if_req  (if_req),
      .ls_req  (ls_req),
      .rr_last (rr_last),
      .fair    (fair_c),
      .gnt_c   (gnt_c)
   );

   // Bus mux and ack routing; a withdrawn request in HOLD simply yields mem_req=0.
   always_comb begin
      gnt_req_c = (gnt_c == SRC_LS) ? ls_req : if_req;
      mem_req   = gnt_req_c & ~rst;
      mem_wen   = 1'b0;
      mem_adr   = if_adr;
      mem_sel   = {SW{1'b1}};
      mem_wdt   = '0;
      if (gnt_c == SRC_LS) begin
         mem_wen = ls_wen;
         mem_adr = ls_adr;
         mem_sel = ls_sel;
         mem_wdt = ls_wdt;
      end
      xfer_c = mem_req & mem_ack;
      if_ack = xfer_c & (gnt_c == SRC_IF);
      ls_ack = xfer_c & (gnt_c == SRC_LS);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (mem_req && !mem_ack)
                     state_nxt = (gnt_c == SRC_LS) ? HOLD_LS : HOLD_IF;
         HOLD_IF: if (!if_req || mem_ack) state_nxt = IDLE;
         HOLD_LS: if (!ls_req || mem_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         rr_last <= SRC_IF;
      end else begin
         state <= state_nxt;
         if (xfer_c) rr_last <= gnt_c;
      end
   end

`ifdef R5P_BUS_ARB_FAIR_EN
   // cnt tracks consecutive LS grants while IF is kept waiting.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         own     <= SRC_IF;
         rd_pend <= 1'b0;
      end else begin
         rd_pend <= xfer_c & ~mem_wen;
         if (xfer_c && !mem_wen) own <= gnt_c;
         if (!if_req)
            cnt <= '0;
         else if (xfer_c) begin
            if (gnt_c == SRC_IF)
               cnt <= '0;
            else if (cnt != CW'(MAXC))
               cnt <= cnt + CW'(1);
         end
      end
   end

   always_comb begin
      if_rdt = mem_rdt;
      ls_rdt = mem_rdt;
      if (rd_pend) begin
         if (own == SRC_IF) ls_rdt = '0;
         else               if_rdt = '0;
      end
   end
`else
   assign if_rdt = mem_rdt;
   assign ls_rdt = mem_rdt;
`endif

endmodule

// File: tb/tb_r5p_bus_arb.sv
// Randomized bench for r5p_bus_arb: fixed-priority and round-robin instances checked against a transaction-level model.
module tb_r5p_bus_arb;

   localparam int unsigned AW   = 32;
   localparam int unsigned DW   = 32;
   localparam int unsigned SW   = DW/8;
   localparam int unsigned MAXC = 4;
`ifdef R5P_BUS_ARB_FAIR_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req, ls_req, ls_wen, mem_ack;
   logic [AW-1:0] if_adr, ls_adr;
   logic [SW-1:0] ls_sel;
   logic [DW-1:0] ls_wdt, mem_rdt;

   logic [DW-1:0] if_rdt [2];
   logic [DW-1:0] ls_rdt [2];
   logic          if_ack [2];
   logic          ls_ack [2];
   logic          mem_req[2];
   logic          mem_wen[2];
   logic [AW-1:0] mem_adr[2];
   logic [SW-1:0] mem_sel[2];
   logic [DW-1:0] mem_wdt[2];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Model state per instance: held requester (0 none, 1 IF, 2 LS), last winner, LS streak, read owner.
   int hold  [2] = '{0, 0};
   int last  [2] = '{0, 0};
   int streak[2] = '{0, 0};
   int rdown [2] = '{0, 0};
   bit rdpend[2] = '{0, 0};

   always #5 clk = ~clk;

   r5p_bus_arb #(.AW(AW), .DW(DW), .SW(SW), .RR(1'b0), .MAXC(MAXC)) u_dut_fp (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_adr(if_adr), .if_rdt(if_rdt[0]), .if_ack(if_ack[0]),
      .ls_req(ls_req), .ls_wen(ls_wen), .ls_adr(ls_adr), .ls_sel(ls_sel), .ls_wdt(ls_wdt),
      .ls_rdt(ls_rdt[0]), .ls_ack(ls_ack[0]),
      .mem_req(mem_req[0]), .mem_wen(mem_wen[0]), .mem_adr(mem_adr[0]), .mem_sel(mem_sel[0]),
      .mem_wdt(mem_wdt[0]), .mem_rdt(mem_rdt), .mem_ack(mem_ack)
   );

   r5p_bus_arb #(.AW(AW), .DW(DW), .SW(SW), .RR(1'b1), .MAXC(MAXC)) u_dut_rr (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_adr(if_adr), .if_rdt(if_rdt[1]), .if_ack(if_ack[1]),
      .ls_req(ls_req), .ls_wen(ls_wen), .ls_adr(ls_adr), .ls_sel(ls_sel), .ls_wdt(ls_wdt),
      .ls_rdt(ls_rdt[1]), .ls_ack(ls_ack[1]),
      .mem_req(mem_req[1]), .mem_wen(mem_wen[1]), .mem_adr(mem_adr[1]), .mem_sel(mem_sel[1]),
      .mem_wdt(mem_wdt[1]), .mem_rdt(mem_rdt), .mem_ack(mem_ack)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic string tg(input string name, input int k);
      return $sformatf("%s[%s]", name, (k == 0) ? "fp" : "rr");
   endfunction

   task automatic drive(input bit ir, input bit lr, input bit wen, input bit ack, input bit r);
      if_req  = ir;
      ls_req  = lr;
      ls_wen  = wen;
      mem_ack = ack;
      rst     = r;
      if_adr  = $urandom;
      ls_adr  = $urandom;
      ls_sel  = SW'($urandom);
      ls_wdt  = $urandom;
      mem_rdt = $urandom;
   endtask

   // Evaluate one cycle: compare outputs against the model mid-cycle, advance the model, then cross the edge.
   task automatic run_cycle();
      int            who;
      bit            act, xfer, wen_e;
      logic [DW-1:0] e_if, e_ls;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         if (hold[k] == 1)      who = 0;
         else if (hold[k] == 2) who = 1;
         else if (if_req && ls_req) begin
            if (FAIR && streak[k] == int'(MAXC)) who = 0;
            else if (k == 1)                     who = (last[k] == 0) ? 1 : 0;
            else                                 who = 1;
         end else
            who = ls_req ? 1 : 0;

         act   = !rst && ((who == 1) ? ls_req : if_req);
         wen_e = (who == 1) && ls_wen;
         xfer  = act && mem_ack;

         check(tg("mem_req", k), 64'(mem_req[k]), 64'(act));
         if (act) begin
            check(tg("mem_adr", k), 64'(mem_adr[k]), 64'((who == 1) ? ls_adr : if_adr));
            check(tg("mem_wen", k), 64'(mem_wen[k]), 64'(wen_e));
            check(tg("mem_sel", k), 64'(mem_sel[k]), 64'((who == 1) ? ls_sel : {SW{1'b1}}));
            check(tg("mem_wdt", k), 64'(mem_wdt[k]), 64'((who == 1) ? ls_wdt : '0));
         end
         check(tg("if_ack", k), 64'(if_ack[k]), 64'(xfer && who == 0));
         check(tg("ls_ack", k), 64'(ls_ack[k]), 64'(xfer && who == 1));

         if (!rst) begin
            e_if = mem_rdt;
            e_ls = mem_rdt;
            if (FAIR && rdpend[k]) begin
               if (rdown[k] == 0) e_ls = '0;
               else               e_if = '0;
            end
            check(tg("if_rdt", k), 64'(if_rdt[k]), 64'(e_if));
            check(tg("ls_rdt", k), 64'(ls_rdt[k]), 64'(e_ls));
         end

         if (rst) begin
            hold[k] = 0; last[k] = 0; streak[k] = 0; rdown[k] = 0; rdpend[k] = 0;
         end else begin
            rdpend[k] = xfer && !wen_e;
            if (xfer && !wen_e) rdown[k] = who;
            hold[k] = (act && !mem_ack) ? who + 1 : 0;
            if (xfer) last[k] = who;
            if (!if_req)   streak[k] = 0;
            else if (xfer) streak[k] = (who == 0) ? 0 :
                                       ((streak[k] < int'(MAXC)) ? streak[k] + 1 : streak[k]);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      drive(0, 0, 0, 0, 1);
      repeat (3) run_cycle();

      // Single fetch acked in the same cycle, read data returned the next cycle.
      drive(1, 0, 0, 1, 0);
      if_adr = 32'h100;
      run_cycle();
      drive(0, 0, 0, 0, 0);
      mem_rdt = 32'hDEAD_BEEF;
      run_cycle();

      // Both requesters every cycle with zero wait states.
      for (int i = 0; i < 15; i++) begin
         drive(1, 1, 0, 1, 0);
         run_cycle();
      end
      drive(0, 0, 0, 0, 0);
      run_cycle();

      // LS write held through three wait states while IF arrives in its second cycle.
      for (int i = 0; i < 5; i++) begin
         drive((i >= 1), (i < 4), 1, (i >= 3), 0);
         ls_adr = 32'h200;
         ls_sel = 4'b0011;
         run_cycle();
      end
      drive(0, 0, 0, 0, 0);
      run_cycle();

      // Reset while LS is held, then IF alone after release.
      drive(0, 1, 0, 0, 0);
      run_cycle();
      drive(0, 1, 0, 0, 1);
      run_cycle();
      drive(1, 0, 0, 1, 0);
      run_cycle();

      // Random traffic including withdrawals, wait states and occasional resets.
      for (int i = 0; i < 4000; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
               $urandom_range(0, 99) == 0);
         run_cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/r5p_bus_arb.md
Name: r5p_bus_arb

Overview:
- Two-to-one arbiter that shares a single memory bus between the core's instruction-fetch port (if_*) and load/store port (ls_*).
- Used in single-memory (von Neumann) SoC variants.
- Adds zero cycles of latency to a granted request, holds the grant through memory wait states, and steers read data, which returns one cycle after ack, to the requester that issued the read.

Parameters:
- AW, 32, address width (all three buses).
- DW, 32, data width (all three buses).
- SW, DW/8, byte select width.
- RR, 1'b0, arbitration policy: 0 = fixed priority (LS wins), 1 = round robin.
- MAXC, 4, fairness limit: max consecutive LS grants while IF waits (used only with R5P_BUS_ARB_FAIR_EN).

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- if_req  input  1  fetch request
- if_adr  input  AW  fetch address
- if_rdt  output  DW  fetch read data
- if_ack  output  1  fetch acknowledge
- ls_req  input  1  load/store request
- ls_wen  input  1  load/store write enable
- ls_adr  input  AW  load/store address
- ls_sel  input  SW  load/store byte select
- ls_wdt  input  DW  load/store write data
- ls_rdt  output  DW  load/store read data
- ls_ack  output  1  load/store acknowledge
- mem_req  output  1  memory request
- mem_wen  output  1  memory write enable
- mem_adr  output  AW  memory address
- mem_sel  output  SW  memory byte select
- mem_wdt  output  DW  memory write data
- mem_rdt  input  DW  memory read data (valid the cycle after mem_req & mem_ack & ~mem_wen)
- mem_ack  input  1  memory acknowledge

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state is reset on the clk edge while rst=1.
- While rst=1: mem_req=0, if_ack=0, ls_ack=0. if_rdt and ls_rdt = mem_rdt (don't care).
- State registers:
  - fsm: IDLE / HOLD_IF / HOLD_LS, reset IDLE.
  - rr_last: last granted requester, reset IF.
  - own: read-data owner, reset IF.
  - cnt: fairness count, reset 0.
- Grant (combinational):
  - HOLD_x grants x unconditionally.
  - IDLE with a single request grants that requester.
  - IDLE with both requests:
    - RR=0: LS.
    - RR=1: the requester not equal to rr_last.
- Muxing: mem_req = granted req. mem_adr, mem_wen, mem_sel and mem_wdt come from the granted port. For IF: mem_wen=0, mem_sel all ones, mem_wdt=0.
- Acks: mem_ack goes only to the granted port's ack, in the same cycle. The ungranted ack is 0.
- FSM transitions:
  - IDLE -> HOLD_x when x is granted and mem_ack=0.
  - HOLD_x -> IDLE on mem_ack=1.
  - HOLD_x -> IDLE if req_x drops before ack: request withdrawn, nothing forwarded afterwards.
  - Any state -> IDLE on rst.
- rr_last updates to the granted requester on every mem_req & mem_ack.
- Read-data steering:
  - On mem_req & mem_ack & ~mem_wen, own <= granted requester.
  - if_rdt and ls_rdt are both driven from mem_rdt. Consumers qualify data with their own registered ack, so this is sufficient.
  - own is used only by the optional feature.
- Back-to-back: an ack on cycle N permits a grant to the other requester on cycle N+1, with no bubble.
- Simultaneous req while HOLD: the other requester waits and its ack stays 0.
- Reset mid-transfer: the hold is dropped and the outstanding read's data is not steered.

Optional Feature:
- Macro: R5P_BUS_ARB_FAIR_EN.
- Defined:
  - cnt counts LS grants (mem_ack) issued while if_req=1. It resets to 0 on any IF grant or when if_req=0.
  - When cnt==MAXC and both requests are present in IDLE, IF is granted regardless of RR.
  - cnt saturates at MAXC.
  - In addition, the non-owner rdt output is driven 0 in the data cycle.
- Undefined: cnt is absent and the pure RR/fixed policy applies.

Decomposition:
- Package r5p_bus_pkg holds:
  - typedef arb_state_t (IDLE, HOLD_IF, HOLD_LS);
  - typedef arb_src_t (SRC_IF, SRC_LS).
- Natural sub-module: r5p_bus_arb_pri, the two-input grant function (policy + fairness override). It is purely combinational; the FSM and registers stay in the top.

Test Plan:
- Only if_req=1, adr=0x100, mem_ack=1 same cycle -> mem_adr=0x100, if_ack=1, ls_ack=0; mem_rdt=0xDEADBEEF next cycle appears on if_rdt.
- RR=0, both req every cycle, mem_ack=1 -> ls granted every cycle, if_ack never 1 (fairness off).
- RR=1, both req, mem_ack=1 -> grants alternate LS, IF, LS, IF starting with LS (rr_last=IF after reset).
- LS write 0x200 sel=4'b0011, mem_ack low 3 cycles, if_req raised in cycle 2 -> mem_* stay on LS for 4 cycles, IF granted cycle 5.
- FAIR_EN, RR=0, MAXC=4, both req, mem_ack=1 -> 4 LS grants, then 1 IF grant, repeating; ls_rdt=0 after the IF read.
- rst asserted during HOLD_LS -> next cycle mem_req=0; after release, fsm is IDLE and IF is granted if it is the sole requester.
